// File: rtl/btb_ctrl_pkg.sv
// Shared types for the BTB update controller: queued update entry and FSM state.
package btb_ctrl_pkg;

    // One pending BTB write; live drops when a later invalidation hits its PC.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic [1:0]  br_type;
        logic        live;
    } btb_upd_t;

    // IDLE: queue empty, DRAIN: queue non-empty, FLUSH: invalidate-all index walk.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } btb_state_t;

    // Word-aligned PC comparison used by the kill logic.
    function automatic logic pc_word_match(input logic [31:0] pc, input logic [29:0] word);
        return pc[31:2] == word;
    endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Update queue: up to two pushes (A then B) and one pop per cycle, plus a
// PC-match kill that clears live on stored entries and on entries landing now.
module btb_upd_fifo
    import btb_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push_a,
    input  btb_upd_t                 entry_a,
    input  logic                     push_b,
    input  btb_upd_t                 entry_b,
    input  logic                     pop,
    input  logic                     kill_en,
    input  logic [29:0]              kill_pc,
    output btb_upd_t                 head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    btb_upd_t        mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr_b;
    logic            pop_ok;
    btb_upd_t        in_a;
    btb_upd_t        in_b;

    // B lands right after A when both push, otherwise in A's slot.
    assign wr_ptr_b = push_a ? wr_ptr + 1'b1 : wr_ptr;
    assign pop_ok   = pop && (count != '0);
    assign head     = mem[rd_ptr];

    // Incoming entries are killed by an invalidation arriving in the same cycle.
    always_comb begin
        in_a      = entry_a;
        in_b      = entry_b;
        in_a.live = entry_a.live && !(kill_en && pc_word_match(entry_a.pc, kill_pc));
        in_b.live = entry_b.live && !(kill_en && pc_word_match(entry_b.pc, kill_pc));
    end

    // Storage: apply the kill to every slot, then write new entries over their slots.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (kill_en && pc_word_match(mem[i].pc, kill_pc)) begin
                mem[i].live <= 1'b0;
            end
        end
        if (push_a) begin
            mem[wr_ptr] <= in_a;
        end
        if (push_b) begin
            mem[wr_ptr_b] <= in_b;
        end
    end

    // Pointers wrap modulo DEPTH; occupancy tracks pushes minus pops.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push_a) + PW'(push_b);
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push_a) + CW'(push_b) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB update controller: queues resolved-branch updates from two ports, drains
// one per cycle into the BTB write port, forwards single-entry invalidations
// (killing matching queued writes) and walks every index on a flush.
module btb_update_ctrl
    import btb_ctrl_pkg::*;
#(
    parameter int SIZE  = 64,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        upd_valid_a,
    input  logic [31:0] upd_pc_a,
    input  logic [31:0] upd_target_a,
    input  logic [1:0]  upd_type_a,
    input  logic        upd_valid_b,
    input  logic [31:0] upd_pc_b,
    input  logic [31:0] upd_target_b,
    input  logic [1:0]  upd_type_b,
    output logic        upd_ready,
    input  logic        inv_valid,
    input  logic [31:0] inv_pc,
    input  logic        flush_req,
    output logic        wr_en,
    output logic [31:0] orig_pc,
    output logic [31:0] target_pc,
    output logic [1:0]  br_type,
    output logic        invalidate,
    output logic [31:0] pc_invalid,
    output logic        busy,
    output logic        flush_done
);

    localparam int IW = $clog2(SIZE);
    localparam int CW = $clog2(DEPTH) + 1;

    btb_state_t      state;
    logic [IW-1:0]   idx;
    logic            inv_pend;
    logic [31:0]     inv_pc_q;
    logic            flush_done_q;

    logic [CW-1:0]   count;
    logic [CW-1:0]   occ_next;
    btb_upd_t        head;
    btb_upd_t        entry_a;
    btb_upd_t        entry_b;
    logic            in_flush;
    logic            head_present;
    logic            flush_go;
    logic            push_a;
    logic            push_b;
    logic            pop;
    logic            kill_en;

    // Handshake: upd_ready comes from registered state only; a port's update is
    // taken at the edge where its valid and upd_ready are both high, otherwise the
    // requester keeps holding it. A flush starting at the same edge drops updates.
    assign in_flush     = (state == FLUSH);
    assign head_present = (count != '0);
    assign flush_go     = flush_req && !in_flush;
    assign upd_ready    = !in_flush && (count <= CW'(DEPTH - 2));
    assign push_a       = upd_valid_a && upd_ready && !flush_go;
    assign push_b       = upd_valid_b && upd_ready && !flush_go;
    assign pop          = head_present && !in_flush;
    assign kill_en      = inv_valid && !in_flush && !flush_req;
    assign occ_next     = count + CW'(push_a) + CW'(push_b) - CW'(pop);

    // Pack incoming updates into queue entries; they start live.
    always_comb begin
        entry_a         = '0;
        entry_a.pc      = upd_pc_a;
        entry_a.target  = upd_target_a;
        entry_a.br_type = upd_type_a;
        entry_a.live    = 1'b1;
        entry_b         = '0;
        entry_b.pc      = upd_pc_b;
        entry_b.target  = upd_target_b;
        entry_b.br_type = upd_type_b;
        entry_b.live    = 1'b1;
    end

    btb_upd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (flush_go),
        .push_a  (push_a),
        .entry_a (entry_a),
        .push_b  (push_b),
        .entry_b (entry_b),
        .pop     (pop),
        .kill_en (kill_en),
        .kill_pc (inv_pc[31:2]),
        .head    (head),
        .count   (count)
    );

    // BTB write port follows the queue head; killed heads pop silently.
    assign wr_en     = head_present && head.live && !in_flush;
    assign orig_pc   = wr_en ? head.pc      : '0;
    assign target_pc = wr_en ? head.target  : '0;
    assign br_type   = wr_en ? head.br_type : '0;

    // Invalidation port: the flush walk owns it while busy.
    assign busy       = in_flush;
    assign invalidate = in_flush || inv_pend;
    assign pc_invalid = in_flush ? {{(30 - IW){1'b0}}, idx, 2'b00}
                                 : (inv_pend ? inv_pc_q : '0);
    assign flush_done = flush_done_q;

    // Controller FSM with flush index counter and registered invalidate/done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            inv_pend     <= 1'b0;
            inv_pc_q     <= '0;
            flush_done_q <= 1'b0;
        end else begin
            flush_done_q <= 1'b0;
            case (state)
                FLUSH: begin
                    inv_pend <= 1'b0;
                    if (idx == IW'(SIZE - 1)) begin
                        state        <= IDLE;
                        idx          <= '0;
                        flush_done_q <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    if (flush_req) begin
                        state    <= FLUSH;
                        idx      <= '0;
                        inv_pend <= 1'b0;
                    end else begin
                        inv_pend <= inv_valid;
                        if (inv_valid) begin
                            inv_pc_q <= inv_pc;
                        end
                        state <= (occ_next != '0) ? DRAIN : IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed bench for btb_update_ctrl (SIZE=64, DEPTH=4).
module tb_btb_update_ctrl;

    localparam int SIZE  = 64;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        upd_valid_a, upd_valid_b;
    logic [31:0] upd_pc_a, upd_pc_b, upd_target_a, upd_target_b;
    logic [1:0]  upd_type_a, upd_type_b;
    logic        upd_ready;
    logic        inv_valid;
    logic [31:0] inv_pc;
    logic        flush_req;
    logic        wr_en;
    logic [31:0] orig_pc, target_pc;
    logic [1:0]  br_type;
    logic        invalidate;
    logic [31:0] pc_invalid;
    logic        busy;
    logic        flush_done;

    int checks = 0;
    int passed = 0;

    btb_update_ctrl #(
        .SIZE  (SIZE),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .upd_valid_a  (upd_valid_a),
        .upd_pc_a     (upd_pc_a),
        .upd_target_a (upd_target_a),
        .upd_type_a   (upd_type_a),
        .upd_valid_b  (upd_valid_b),
        .upd_pc_b     (upd_pc_b),
        .upd_target_b (upd_target_b),
        .upd_type_b   (upd_type_b),
        .upd_ready    (upd_ready),
        .inv_valid    (inv_valid),
        .inv_pc       (inv_pc),
        .flush_req    (flush_req),
        .wr_en        (wr_en),
        .orig_pc      (orig_pc),
        .target_pc    (target_pc),
        .br_type      (br_type),
        .invalidate   (invalidate),
        .pc_invalid   (pc_invalid),
        .busy         (busy),
        .flush_done   (flush_done)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        upd_valid_a  = 1'b0; upd_pc_a = '0; upd_target_a = '0; upd_type_a = '0;
        upd_valid_b  = 1'b0; upd_pc_b = '0; upd_target_b = '0; upd_type_b = '0;
        inv_valid    = 1'b0; inv_pc = '0;
        flush_req    = 1'b0;
    endtask

    task automatic drive_a(input logic [31:0] pc, input logic [31:0] tgt, input logic [1:0] ty);
        upd_valid_a = 1'b1; upd_pc_a = pc; upd_target_a = tgt; upd_type_a = ty;
    endtask

    task automatic drive_b(input logic [31:0] pc, input logic [31:0] tgt, input logic [1:0] ty);
        upd_valid_b = 1'b1; upd_pc_b = pc; upd_target_b = tgt; upd_type_b = ty;
    endtask

    // Reset values of every output.
    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        cyc();
        cyc();
        checks++;
        if ({wr_en, invalidate, busy, flush_done, upd_ready} !== 5'b00001)
            $display("FAIL reset_flags: got %b want 00001", {wr_en, invalidate, busy, flush_done, upd_ready});
        else passed++;
        checks++;
        if ({orig_pc, target_pc, br_type, pc_invalid} !== 98'd0)
            $display("FAIL reset_pcs: got orig=%h tgt=%h type=%0d inv=%h want zeros", orig_pc, target_pc, br_type, pc_invalid);
        else passed++;
        rst_n = 1'b1;
        cyc();
    endtask

    // One update on port A appears on the write port the next cycle only.
    task automatic test_single_update();
        checks++;
        if (wr_en !== 1'b0) $display("FAIL single_pre: wr_en got %b want 0", wr_en); else passed++;
        drive_a(32'h100, 32'h200, 2'd1);
        cyc();
        clear_inputs();
        checks++;
        if ({wr_en, orig_pc, target_pc, br_type} !== {1'b1, 32'h100, 32'h200, 2'd1})
            $display("FAIL single_write: got wr=%b pc=%h tgt=%h type=%0d want 1/100/200/1", wr_en, orig_pc, target_pc, br_type);
        else passed++;
        cyc();
        checks++;
        if (wr_en !== 1'b0) $display("FAIL single_once: wr_en got %b want 0", wr_en); else passed++;
    endtask

    // Both ports valid every cycle; requester holds a pair until upd_ready.
    task automatic test_back_to_back();
        logic [31:0] exp_q[$];
        logic [31:0] h;
        logic        exp_ready;
        int          model_count = 0;
        int          k = 0;
        int          written = 0;
        for (int c = 0; c < 40 && written < 12; c++) begin
            exp_ready = (model_count <= DEPTH - 2);
            checks++;
            if (upd_ready !== exp_ready)
                $display("FAIL b2b_ready c%0d: got %b want %b", c, upd_ready, exp_ready);
            else passed++;
            if (model_count > 0) begin
                h = exp_q[0];
                checks++;
                if (wr_en !== 1'b1 || orig_pc !== h || target_pc !== h + 32'h40 || br_type !== h[4:3])
                    $display("FAIL b2b_write c%0d: got wr=%b pc=%h tgt=%h type=%0d want pc=%h", c, wr_en, orig_pc, target_pc, br_type, h);
                else passed++;
                void'(exp_q.pop_front());
                model_count--;
                written++;
            end else begin
                checks++;
                if (wr_en !== 1'b0) $display("FAIL b2b_idle c%0d: wr_en got %b want 0", c, wr_en); else passed++;
            end
            if (k < 6) begin
                h = 32'h1000 + 32'(8 * k);
                drive_a(h, h + 32'h40, h[4:3]);
                drive_b(h + 32'h4, h + 32'h44, h[4:3]);
                if (exp_ready) begin
                    exp_q.push_back(h);
                    exp_q.push_back(h + 32'h4);
                    model_count += 2;
                    k++;
                end
            end else begin
                clear_inputs();
            end
            cyc();
        end
        clear_inputs();
        checks++;
        if ({wr_en, upd_ready} !== 2'b01) $display("FAIL b2b_drained: got wr=%b rdy=%b want 0/1", wr_en, upd_ready); else passed++;
    endtask

    // Invalidation kills both queued 0x100 entries; 0x104 still written.
    task automatic test_inv_kill();
        drive_a(32'h300, 32'h3300, 2'd2);
        drive_b(32'h100, 32'h1100, 2'd2);
        cyc();
        clear_inputs();
        checks++;
        if ({wr_en, orig_pc} !== {1'b1, 32'h300}) $display("FAIL kill_first: got wr=%b pc=%h want 1/300", wr_en, orig_pc); else passed++;
        drive_a(32'h104, 32'h1104, 2'd3);
        drive_b(32'h100, 32'h2100, 2'd2);
        inv_valid = 1'b1;
        inv_pc    = 32'h100;
        cyc();
        clear_inputs();
        checks++;
        if ({wr_en, invalidate, pc_invalid, upd_ready} !== {1'b0, 1'b1, 32'h100, 1'b0})
            $display("FAIL kill_head: got wr=%b inv=%b pci=%h rdy=%b want 0/1/100/0", wr_en, invalidate, pc_invalid, upd_ready);
        else passed++;
        cyc();
        checks++;
        if ({wr_en, orig_pc, target_pc, br_type, invalidate} !== {1'b1, 32'h104, 32'h1104, 2'd3, 1'b0})
            $display("FAIL kill_survivor: got wr=%b pc=%h tgt=%h type=%0d inv=%b want 1/104/1104/3/0", wr_en, orig_pc, target_pc, br_type, invalidate);
        else passed++;
        cyc();
        checks++;
        if (wr_en !== 1'b0) $display("FAIL kill_tail: wr_en got %b want 0", wr_en); else passed++;
        cyc();
        checks++;
        if ({wr_en, upd_ready} !== 2'b01) $display("FAIL kill_empty: got wr=%b rdy=%b want 0/1", wr_en, upd_ready); else passed++;
    endtask

    // Flush with three queued entries walks every index then pulses done.
    task automatic test_flush();
        drive_a(32'h500, 32'h600, 2'd0);
        drive_b(32'h504, 32'h604, 2'd0);
        cyc();
        checks++;
        if ({wr_en, orig_pc} !== {1'b1, 32'h500}) $display("FAIL flush_pre0: got wr=%b pc=%h want 1/500", wr_en, orig_pc); else passed++;
        drive_a(32'h508, 32'h608, 2'd0);
        drive_b(32'h50C, 32'h60C, 2'd0);
        cyc();
        clear_inputs();
        checks++;
        if ({wr_en, orig_pc, upd_ready} !== {1'b1, 32'h504, 1'b0}) $display("FAIL flush_pre1: got wr=%b pc=%h rdy=%b want 1/504/0", wr_en, orig_pc, upd_ready); else passed++;
        flush_req = 1'b1;
        inv_valid = 1'b1;
        inv_pc    = 32'h508;
        cyc();
        clear_inputs();
        for (int i = 0; i < SIZE; i++) begin
            checks++;
            if ({wr_en, invalidate, busy, flush_done, upd_ready} !== 5'b01100 || pc_invalid !== 32'(4 * i))
                $display("FAIL flush_walk i%0d: got flags=%b pci=%h want 01100/%h", i, {wr_en, invalidate, busy, flush_done, upd_ready}, pc_invalid, 32'(4 * i));
            else passed++;
            if (i == 10) begin
                flush_req = 1'b1;
                inv_valid = 1'b1;
                inv_pc    = 32'hABC;
                drive_a(32'h700, 32'h800, 2'd1);
                drive_b(32'h704, 32'h804, 2'd1);
            end else begin
                clear_inputs();
            end
            cyc();
        end
        checks++;
        if ({wr_en, invalidate, busy, flush_done, upd_ready} !== 5'b00011 || pc_invalid !== 32'h0)
            $display("FAIL flush_done: got flags=%b pci=%h want 00011/0", {wr_en, invalidate, busy, flush_done, upd_ready}, pc_invalid);
        else passed++;
        cyc();
        checks++;
        if ({wr_en, invalidate, busy, flush_done, upd_ready} !== 5'b00001)
            $display("FAIL flush_after: got flags=%b want 00001", {wr_en, invalidate, busy, flush_done, upd_ready});
        else passed++;
    endtask

    // Reset in the middle of a walk aborts it with no done pulse.
    task automatic test_reset_during_flush();
        logic saw_done = 1'b0;
        flush_req = 1'b1;
        cyc();
        clear_inputs();
        for (int i = 0; i <= 20; i++) begin
            checks++;
            if ({busy, invalidate} !== 2'b11 || pc_invalid !== 32'(4 * i))
                $display("FAIL rstfl_walk i%0d: got busy=%b inv=%b pci=%h want 1/1/%h", i, busy, invalidate, pc_invalid, 32'(4 * i));
            else passed++;
            if (i == 20) rst_n = 1'b0;
            cyc();
        end
        checks++;
        if ({wr_en, invalidate, busy, flush_done, upd_ready} !== 5'b00001 || pc_invalid !== 32'h0)
            $display("FAIL rstfl_abort: got flags=%b pci=%h want 00001/0", {wr_en, invalidate, busy, flush_done, upd_ready}, pc_invalid);
        else passed++;
        rst_n = 1'b1;
        for (int i = 0; i < SIZE + 4; i++) begin
            cyc();
            if (flush_done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) $display("FAIL rstfl_no_done: flush_done/busy seen %b want 0", saw_done); else passed++;
        drive_a(32'h40, 32'h80, 2'd3);
        cyc();
        clear_inputs();
        checks++;
        if ({wr_en, orig_pc, target_pc, br_type} !== {1'b1, 32'h40, 32'h80, 2'd3})
            $display("FAIL rstfl_resume: got wr=%b pc=%h tgt=%h type=%0d want 1/40/80/3", wr_en, orig_pc, target_pc, br_type);
        else passed++;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_single_update();
        test_back_to_back();
        test_inv_kill();
        test_flush();
        test_reset_during_flush();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
